// File: rtl/day10_min_presses_solver.sv
// day10_min_presses_solver
// Finds the minimum number of button presses whose XOR of light masks equals
// the target arrangement. Button subsets are walked in Gray-code order, one
// subset per clock, so each step flips exactly one button in or out.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_valid/in_ready machine descriptor handshake (ready while idle)
//   in_num_lights     active light count
//   in_num_buttons    active button count
//   in_buttons        button b at [b*MAX_NUM_LIGHTS +: MAX_NUM_LIGHTS]
//   in_target         target light arrangement
//   out_valid/out_ready  result handshake
//   out_min_presses   minimum presses (0 when unsolvable)
//   out_solvable      at least one subset matched
//   total_clear       zeroes the running totals (wins over a handshake)
//   total_presses     sum of min presses over accepted solvable results
//   machines_done     count of result handshakes
module day10_min_presses_solver #(
    parameter int MAX_NUM_LIGHTS  = 10,
    parameter int MAX_NUM_BUTTONS = 13,
    parameter int TOTAL_W         = 32,
    localparam int NB_W = ($clog2(MAX_NUM_BUTTONS + 1) < 1) ? 1 : $clog2(MAX_NUM_BUTTONS + 1),
    localparam int NL_W = ($clog2(MAX_NUM_LIGHTS + 1) < 1) ? 1 : $clog2(MAX_NUM_LIGHTS + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [NL_W-1:0]                       in_num_lights,
    input  logic [NB_W-1:0]                       in_num_buttons,
    input  logic [MAX_NUM_BUTTONS*MAX_NUM_LIGHTS-1:0] in_buttons,
    input  logic [MAX_NUM_LIGHTS-1:0]             in_target,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [NB_W-1:0]                       out_min_presses,
    output logic                                  out_solvable,
    input  logic                                  total_clear,
    output logic [TOTAL_W-1:0]                    total_presses,
    output logic [TOTAL_W-1:0]                    machines_done
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    state_t                      state;
    logic [MAX_NUM_LIGHTS-1:0]   btn [MAX_NUM_BUTTONS];
    logic [MAX_NUM_LIGHTS-1:0]   target_q;
    logic [MAX_NUM_LIGHTS-1:0]   acc;
    logic [MAX_NUM_BUTTONS-1:0]  k;
    logic [MAX_NUM_BUTTONS-1:0]  gray;
    logic [MAX_NUM_BUTTONS-1:0]  last_k;
    logic [NB_W-1:0]             pop;
    logic [NB_W-1:0]             best;
    logic                        found;

    // Combinational helpers
    logic [MAX_NUM_LIGHTS-1:0]   light_mask;
    logic [MAX_NUM_BUTTONS-1:0]  new_last_k;
    logic [MAX_NUM_BUTTONS-1:0]  k_inc;
    logic [MAX_NUM_BUTTONS-1:0]  flip;
    logic [MAX_NUM_LIGHTS-1:0]   btn_sel;
    logic                        gray_bit;
    logic                        hit;
    logic                        found_nx;
    logic [NB_W-1:0]             best_nx;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_comb begin
        light_mask = '0;
        for (int unsigned i = 0; i < MAX_NUM_LIGHTS; i++)
            light_mask[i] = (i < 32'(in_num_lights));
        // last_k = 2^num_buttons - 1 as a thermometer code
        new_last_k = '0;
        for (int unsigned j = 0; j < MAX_NUM_BUTTONS; j++)
            new_last_k[j] = (j < 32'(in_num_buttons));
    end

    // The lowest set bit of k+1 is the trailing-zero position, i.e. the
    // button whose membership flips in the Gray sequence.
    always_comb begin
        k_inc    = k + 1'b1;
        flip     = k_inc & ~k;
        btn_sel  = '0;
        for (int unsigned i = 0; i < MAX_NUM_BUTTONS; i++)
            if (flip[i]) btn_sel = btn_sel | btn[i];
        gray_bit = |(gray & flip);
        hit      = (acc == target_q) && (!found || (pop < best));
        found_nx = found | hit;
        best_nx  = hit ? pop : best;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            out_min_presses <= '0;
            out_solvable    <= 1'b0;
            total_presses   <= '0;
            machines_done   <= '0;
            k               <= '0;
            gray            <= '0;
            last_k          <= '0;
            acc             <= '0;
            target_q        <= '0;
            pop             <= '0;
            best            <= '1;
            found           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int unsigned b = 0; b < MAX_NUM_BUTTONS; b++)
                            btn[b] <= (b < 32'(in_num_buttons))
                                    ? (in_buttons[b*MAX_NUM_LIGHTS +: MAX_NUM_LIGHTS] & light_mask)
                                    : '0;
                        target_q <= in_target & light_mask;
                        last_k   <= new_last_k;
                        k        <= '0;
                        gray     <= '0;
                        acc      <= '0;
                        pop      <= '0;
                        best     <= '1;
                        found    <= 1'b0;
                        state    <= SEARCH;
                    end
                end
                SEARCH: begin
                    found <= found_nx;
                    best  <= best_nx;
                    if (k == last_k) begin
                        out_solvable    <= found_nx;
                        out_min_presses <= found_nx ? best_nx : '0;
                        state           <= DONE;
                    end else begin
                        k    <= k_inc;
                        acc  <= acc ^ btn_sel;
                        gray <= gray ^ flip;
                        pop  <= gray_bit ? (pop - 1'b1) : (pop + 1'b1);
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (total_clear) begin
                total_presses <= '0;
                machines_done <= '0;
            end else if (state == DONE && out_ready) begin
                machines_done <= machines_done + 1'b1;
                if (out_solvable)
                    total_presses <= total_presses + TOTAL_W'(out_min_presses);
            end
        end
    end

endmodule

// File: tb/tb_day10_min_presses_solver.sv
// tb_day10_min_presses_solver
// Directed bench for day10_min_presses_solver: reset, mid-search reset,
// three streamed example machines, unsolvable and masking edge cases,
// backpressure and total_clear on a handshake.
module tb_day10_min_presses_solver;

    localparam int L   = 10;
    localparam int B   = 13;
    localparam int T   = 32;
    localparam int NBW = 4;
    localparam int NLW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [NLW-1:0]  in_num_lights;
    logic [NBW-1:0]  in_num_buttons;
    logic [B*L-1:0]  in_buttons;
    logic [L-1:0]    in_target;
    logic            out_valid;
    logic            out_ready;
    logic [NBW-1:0]  out_min_presses;
    logic            out_solvable;
    logic            total_clear;
    logic [T-1:0]    total_presses;
    logic [T-1:0]    machines_done;

    logic [B*L-1:0]  bv;
    int              n_checks = 0;
    int              n_fail   = 0;

    day10_min_presses_solver #(
        .MAX_NUM_LIGHTS (L),
        .MAX_NUM_BUTTONS(B),
        .TOTAL_W        (T)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_num_lights  (in_num_lights),
        .in_num_buttons (in_num_buttons),
        .in_buttons     (in_buttons),
        .in_target      (in_target),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_min_presses(out_min_presses),
        .out_solvable   (out_solvable),
        .total_clear    (total_clear),
        .total_presses  (total_presses),
        .machines_done  (machines_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input int b, input logic [L-1:0] m);
        bv[b*L +: L] = m;
    endtask

    // Called at a negedge with the solver idle; returns at the negedge of
    // the first cycle after the accept edge. Inputs are then scrambled.
    task automatic submit(input logic [NLW-1:0] nl, input logic [NBW-1:0] nb,
                          input logic [L-1:0] tgt);
        check("accept_ready", in_ready, 1);
        in_valid       = 1'b1;
        in_num_lights  = nl;
        in_num_buttons = nb;
        in_buttons     = bv;
        in_target      = tgt;
        @(negedge clk);
        in_valid       = 1'b0;
        in_num_lights  = 4'd10;
        in_num_buttons = 4'd13;
        in_buttons     = '1;
        in_target      = '1;
    endtask

    task automatic wait_result(input string tag, input int exp_lat,
                               input logic [NBW-1:0] exp_min, input logic exp_solv);
        int cyc = 1;
        while (!out_valid && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_latency"}, cyc, exp_lat);
        check({tag, "_min"}, out_min_presses, exp_min);
        check({tag, "_solvable"}, out_solvable, exp_solv);
    endtask

    task automatic handshake(input logic clr);
        out_ready   = 1'b1;
        total_clear = clr;
        @(negedge clk);
        out_ready   = 1'b0;
        total_clear = 1'b0;
    endtask

    task automatic check_totals(input string tag, input int exp_tot, input int exp_done);
        check({tag, "_total"}, total_presses, exp_tot);
        check({tag, "_done"}, machines_done, exp_done);
    endtask

    task automatic load_m1();
        bv = '0;
        set_btn(0, 10'b1000);
        set_btn(1, 10'b1010);
        set_btn(2, 10'b0100);
        set_btn(3, 10'b1100);
        set_btn(4, 10'b0101);
        set_btn(5, 10'b0011);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; total_clear = 1'b0;
        in_num_lights = '0; in_num_buttons = '0; in_buttons = '0; in_target = '0;
        bv = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_min", out_min_presses, 0);
        check("rst_solvable", out_solvable, 0);
        check_totals("rst", 0, 0);

        // Reset in the middle of a search discards the machine
        load_m1();
        submit(4'd4, 4'd6, 10'b0110);
        repeat (5) @(negedge clk);
        check("busy_in_ready", in_ready, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check_totals("midrst", 0, 0);

        // Machine 1
        load_m1();
        submit(4'd4, 4'd6, 10'b0110);
        wait_result("m1", 65, 4'd2, 1'b1);
        handshake(1'b0);
        check_totals("m1", 2, 1);

        // Machine 2, streamed right after
        bv = '0;
        set_btn(0, 10'b11101);
        set_btn(1, 10'b01100);
        set_btn(2, 10'b10001);
        set_btn(3, 10'b00111);
        set_btn(4, 10'b11110);
        submit(4'd5, 4'd5, 10'b01000);
        wait_result("m2", 33, 4'd3, 1'b1);
        handshake(1'b0);
        check_totals("m2", 5, 2);

        // Machine 3
        bv = '0;
        set_btn(0, 10'b011111);
        set_btn(1, 10'b011001);
        set_btn(2, 10'b110111);
        set_btn(3, 10'b000110);
        submit(4'd6, 4'd4, 10'b101110);
        wait_result("m3", 17, 4'd2, 1'b1);
        handshake(1'b0);
        check_totals("m3", 7, 3);

        // Unsolvable
        bv = '0;
        set_btn(0, 10'b11);
        submit(4'd2, 4'd1, 10'b01);
        wait_result("unsolv", 3, 4'd0, 1'b0);
        handshake(1'b0);
        check_totals("unsolv", 7, 4);

        // No buttons, zero target: one evaluation of the empty subset
        bv = '1;
        submit(4'd3, 4'd0, 10'b0);
        wait_result("nb0", 2, 4'd0, 1'b1);
        handshake(1'b0);
        check_totals("nb0", 7, 5);

        // Target and button bits above num_lights, buttons beyond num_buttons
        bv = '0;
        set_btn(0, 10'h303);
        set_btn(1, 10'h001);
        set_btn(2, 10'h002);
        set_btn(12, 10'h3FF);
        submit(4'd3, 4'd2, 10'h3FA);
        wait_result("mask", 5, 4'd2, 1'b1);
        handshake(1'b0);
        check_totals("mask", 9, 6);

        // Zero lights: always solvable with 0 presses
        bv = '0;
        set_btn(0, 10'h3FF);
        set_btn(1, 10'h155);
        submit(4'd0, 4'd2, 10'h3FF);
        wait_result("nl0", 5, 4'd0, 1'b1);
        handshake(1'b0);
        check_totals("nl0", 9, 7);

        // Backpressure then a handshake coinciding with total_clear
        load_m1();
        submit(4'd4, 4'd6, 10'b0110);
        wait_result("bp", 65, 4'd2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_min", out_min_presses, 2);
            check("bp_solvable", out_solvable, 1);
        end
        check_totals("bp_hold", 9, 7);
        handshake(1'b1);
        check("clr_in_ready", in_ready, 1);
        check_totals("clr", 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
